// File: rtl/cpu_pkg.sv
// Shared types and default widths for the 16-bit CPU pipeline.
package cpu_pkg;

  localparam int unsigned CPU_DATA_W = 16;
  localparam int unsigned CPU_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } mem_state_t;

  // Control bundle captured from EX/MEM when a memory access is launched.
  typedef struct packed {
    logic rd;
    logic wr;
    logic wbs;
    logic ni;
  } mem_ctrl_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating wait-cycle counter; expired_c flags the cycle whose increment reaches TIMEOUT.
module mem_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // Saturates at TIMEOUT so the counter can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_W'(TIMEOUT))) begin
      count <= count + 1'b1;
    end
  end

  assign expired_c = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: performs loads/stores over a req/ready bus, stalls upstream while busy,
// and presents registered results with a one-cycle valid strobe to the MEM/WB register.
module memory_access_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W  = CPU_DATA_W,
  parameter int unsigned ADDR_W  = CPU_ADDR_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              wbs_in,
  input  logic              ni_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic              flush,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              valid_out,
  output logic              wbs_out,
  output logic              ni_out,
  output logic [DATA_W-1:0] ALUresult_out,
  output logic [DATA_W-1:0] memData_out,
  output logic              bus_error
);

  mem_state_t        state, state_next;
  mem_ctrl_t         ctrl_q;
  logic [DATA_W-1:0] alu_q;
  logic              kill_q;

  logic              accept_c, alu_pass_c, launch_c, illegal_c, done_c, expired_c;
  logic              valid_d, wbs_d, ni_d, kill_d;
  logic [DATA_W-1:0] alu_d, mem_data_d;

  assign accept_c   = (state == IDLE) && valid_in && !flush;
  assign alu_pass_c = accept_c && !mem_read_in && !mem_write_in;
  assign launch_c   = accept_c && (mem_read_in ^ mem_write_in);
  assign illegal_c  = accept_c && mem_read_in && mem_write_in;
  assign done_c     = (state == ACCESS) && mem_ready;

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear     (launch_c),
    .enable    ((state == ACCESS) && !mem_ready),
    .expired_c (expired_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ERR is terminal until reset; a completing access wins over a same-cycle timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (illegal_c) begin
          state_next = ERR;
        end else if (launch_c) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_next = IDLE;
        end else if (expired_c) begin
          state_next = ERR;
        end
      end
      ERR:     state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  // Next values for the result register and the kill flag.
  always_comb begin
    valid_d    = alu_pass_c || (done_c && !kill_q && !flush);
    alu_d      = alu_q;
    wbs_d      = ctrl_q.wbs;
    ni_d       = ctrl_q.ni;
    mem_data_d = (ctrl_q.rd && !ctrl_q.wr) ? mem_rdata : '0;
    kill_d     = kill_q;
    if (alu_pass_c) begin
      alu_d      = alu_result_in;
      wbs_d      = wbs_in;
      ni_d       = ni_in;
      mem_data_d = '0;
    end
    if (state_next == IDLE) begin
      kill_d = 1'b0;
    end else if ((state == ACCESS) && flush) begin
      kill_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_out     <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      valid_out     <= 1'b0;
      wbs_out       <= 1'b0;
      ni_out        <= 1'b0;
      ALUresult_out <= '0;
      memData_out   <= '0;
      bus_error     <= 1'b0;
      ctrl_q        <= '0;
      alu_q         <= '0;
      kill_q        <= 1'b0;
    end else begin
      stall_out <= (state_next != IDLE);
      mem_req   <= (state_next == ACCESS);
      bus_error <= bus_error || (state_next == ERR);
      valid_out <= valid_d;
      kill_q    <= kill_d;
      if (valid_d) begin
        ALUresult_out <= alu_d;
        memData_out   <= mem_data_d;
        wbs_out       <= wbs_d;
        ni_out        <= ni_d;
      end
      // Bus fields stay frozen for the whole access.
      if (launch_c) begin
        ctrl_q    <= '{rd: mem_read_in, wr: mem_write_in, wbs: wbs_in, ni: ni_in};
        alu_q     <= alu_result_in;
        mem_addr  <= ADDR_W'(alu_result_in);
        mem_we    <= mem_write_in;
        mem_wdata <= store_data_in;
      end
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: stimulus queues expected results and status probes,
// a negedge monitor compares them against the DUT.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, mem_read_in, mem_write_in, wbs_in, ni_in, flush;
  logic [15:0] alu_result_in, store_data_in;
  logic        stall_out, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        valid_out, wbs_out, ni_out, bus_error;
  logic [15:0] ALUresult_out, memData_out;

  memory_access_stage #(
    .DATA_W  (16),
    .ADDR_W  (16),
    .TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .mem_read_in   (mem_read_in),
    .mem_write_in  (mem_write_in),
    .wbs_in        (wbs_in),
    .ni_in         (ni_in),
    .alu_result_in (alu_result_in),
    .store_data_in (store_data_in),
    .flush         (flush),
    .stall_out     (stall_out),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .valid_out     (valid_out),
    .wbs_out       (wbs_out),
    .ni_out        (ni_out),
    .ALUresult_out (ALUresult_out),
    .memData_out   (memData_out),
    .bus_error     (bus_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] mdata;
    logic        wbs;
    logic        ni;
  } res_t;

  typedef enum {K_MARK, K_STALL, K_REQ, K_BUSERR, K_VALID, K_ALU, K_MDATA, K_WBS, K_NI,
                K_REQCNT, K_STALLCNT, K_SBLEFT} kind_t;

  typedef struct {
    kind_t kind;
    string name;
    int    exp;
  } probe_t;

  res_t   sb[$];
  probe_t pq[$];
  int     errors = 0;
  int     checks = 0;
  int     req_cnt = 0;
  int     stall_cnt = 0;
  int     wait_cycles = 0;
  int     resp_cnt = 0;
  logic [15:0] rdata_cfg = 16'h0000;
  logic [15:0] exp_addr = 16'h0000;
  logic [15:0] exp_wdata = 16'h0000;
  logic        exp_we = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: answers after wait_cycles request cycles, forgets abandoned requests.
  always @(negedge clk) begin
    if (mem_req) begin
      mem_ready = (resp_cnt == wait_cycles);
      mem_rdata = mem_ready ? rdata_cfg : 16'hDEAD;
      resp_cnt++;
    end else begin
      mem_ready = 1'b0;
      resp_cnt  = 0;
    end
  end

  always @(negedge clk) begin : monitor
    res_t   e;
    probe_t p;
    int     act;
    if (mem_req) begin
      req_cnt++;
      chk("mem_addr", int'(mem_addr), int'(exp_addr));
      chk("mem_we", int'(mem_we), int'(exp_we));
      if (exp_we) chk("mem_wdata", int'(mem_wdata), int'(exp_wdata));
    end
    if (stall_out) stall_cnt++;
    if (valid_out) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: valid_out=1 ALUresult_out=%h but nothing expected at %0t",
                 ALUresult_out, $time);
      end else begin
        e = sb.pop_front();
        chk("res_alu", int'(ALUresult_out), int'(e.alu));
        chk("res_memdata", int'(memData_out), int'(e.mdata));
        chk("res_wbs", int'(wbs_out), int'(e.wbs));
        chk("res_ni", int'(ni_out), int'(e.ni));
      end
    end
    while (pq.size() > 0) begin
      p = pq.pop_front();
      act = 0;
      case (p.kind)
        K_STALL:    act = int'(stall_out);
        K_REQ:      act = int'(mem_req);
        K_BUSERR:   act = int'(bus_error);
        K_VALID:    act = int'(valid_out);
        K_ALU:      act = int'(ALUresult_out);
        K_MDATA:    act = int'(memData_out);
        K_WBS:      act = int'(wbs_out);
        K_NI:       act = int'(ni_out);
        K_REQCNT:   act = req_cnt;
        K_STALLCNT: act = stall_cnt;
        K_SBLEFT:   act = sb.size();
        default:    act = 0;
      endcase
      if (p.kind == K_MARK) begin
        req_cnt   = 0;
        stall_cnt = 0;
      end else begin
        chk(p.name, act, p.exp);
      end
    end
  end

  task automatic probe(input kind_t k, input string n, input int e);
    probe_t p;
    p.kind = k;
    p.name = n;
    p.exp  = e;
    pq.push_back(p);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic wbs, input logic ni,
                       input logic [15:0] alu, input logic [15:0] sd);
    valid_in      = 1'b1;
    mem_read_in   = rd;
    mem_write_in  = wr;
    wbs_in        = wbs;
    ni_in         = ni;
    alu_result_in = alu;
    store_data_in = sd;
    cyc(1);
  endtask

  task automatic idle_in();
    valid_in     = 1'b0;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
  endtask

  // Bounded wait for the stage to drain; an expired bound shows up as a failing stall probe.
  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!stall_out) break;
      cyc(1);
    end
    probe(K_STALL, "stall_drained", 0);
  endtask

  task automatic expect_res(input logic [15:0] alu, input logic [15:0] md, input logic wbs,
                            input logic ni);
    res_t r;
    r.alu   = alu;
    r.mdata = md;
    r.wbs   = wbs;
    r.ni    = ni;
    sb.push_back(r);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    wbs_in = 1'b0;
    ni_in = 1'b0;
    alu_result_in = '0;
    store_data_in = '0;
    idle_in();
    cyc(2);
    probe(K_VALID, "rst_valid", 0);
    probe(K_REQ, "rst_req", 0);
    probe(K_STALL, "rst_stall", 0);
    probe(K_BUSERR, "rst_buserr", 0);
    probe(K_ALU, "rst_alu", 0);
    probe(K_MDATA, "rst_mdata", 0);
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // ALU pass-through
    probe(K_MARK, "", 0);
    expect_res(16'h1234, 16'h0000, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000);
    idle_in();
    cyc(2);
    probe(K_STALLCNT, "alu_stall_cnt", 0);

    // Back-to-back ALU ops, one per cycle
    expect_res(16'h1111, 16'h0000, 1'b1, 1'b0);
    expect_res(16'h2222, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h1111, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h2222, 16'h0000);
    idle_in();
    cyc(2);

    // Load with three wait cycles
    wait_cycles = 3;
    rdata_cfg = 16'hBEEF;
    exp_addr = 16'h0040;
    exp_we = 1'b0;
    probe(K_MARK, "", 0);
    expect_res(16'h0040, 16'hBEEF, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h5555);
    idle_in();
    wait_idle(20);
    probe(K_REQCNT, "load_req_cycles", 4);
    probe(K_STALLCNT, "load_stall_cycles", 4);
    cyc(2);

    // Store ready on the first request cycle
    wait_cycles = 0;
    exp_addr = 16'h0010;
    exp_we = 1'b1;
    exp_wdata = 16'h00AA;
    probe(K_MARK, "", 0);
    expect_res(16'h0010, 16'h0000, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h00AA);
    idle_in();
    wait_idle(20);
    probe(K_REQCNT, "store_req_cycles", 1);
    cyc(2);

    // Flushed load completes on the bus but never retires
    wait_cycles = 2;
    rdata_cfg = 16'hCAFE;
    exp_addr = 16'h0080;
    exp_we = 1'b0;
    probe(K_MARK, "", 0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0080, 16'h0000);
    idle_in();
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    wait_idle(20);
    probe(K_REQCNT, "flush_req_cycles", 3);
    probe(K_ALU, "flush_alu_hold", 16'h0010);
    cyc(2);
    expect_res(16'h0F0F, 16'h0000, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0F0F, 16'h0000);
    idle_in();
    cyc(2);

    // Read and write together is illegal
    probe(K_MARK, "", 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0033, 16'h0000);
    idle_in();
    probe(K_BUSERR, "illegal_buserr", 1);
    probe(K_STALL, "illegal_stall", 1);
    cyc(3);
    probe(K_REQCNT, "illegal_req_cycles", 0);
    probe(K_BUSERR, "illegal_buserr_sticky", 1);
    cyc(1);
    pulse_rst();
    probe(K_BUSERR, "illegal_rst_buserr", 0);
    probe(K_STALL, "illegal_rst_stall", 0);
    cyc(2);

    // Memory never answers: timeout after four request cycles
    wait_cycles = 1000;
    exp_addr = 16'h0100;
    exp_we = 1'b0;
    probe(K_MARK, "", 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000);
    idle_in();
    cyc(6);
    probe(K_BUSERR, "timeout_buserr", 1);
    probe(K_REQ, "timeout_req", 0);
    probe(K_STALL, "timeout_stall", 1);
    probe(K_REQCNT, "timeout_req_cycles", 4);
    cyc(1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h7777, 16'h0000);
    idle_in();
    cyc(2);
    probe(K_BUSERR, "err_sticky", 1);
    probe(K_STALL, "err_stall", 1);
    cyc(1);
    pulse_rst();
    probe(K_BUSERR, "timeout_rst_buserr", 0);
    probe(K_STALL, "timeout_rst_stall", 0);
    cyc(2);

    // Asynchronous reset in the middle of an access
    expect_res(16'hA5A5, 16'h0000, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'hA5A5, 16'h0000);
    idle_in();
    cyc(2);
    exp_addr = 16'h0200;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0200, 16'h0000);
    idle_in();
    cyc(1);
    #2;
    rst = 1'b1;
    probe(K_REQ, "arst_req", 0);
    probe(K_STALL, "arst_stall", 0);
    probe(K_VALID, "arst_valid", 0);
    probe(K_ALU, "arst_alu", 0);
    probe(K_WBS, "arst_wbs", 0);
    probe(K_NI, "arst_ni", 0);
    probe(K_MDATA, "arst_mdata", 0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    expect_res(16'h4321, 16'h0000, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h4321, 16'h0000);
    idle_in();
    cyc(2);

    probe(K_SBLEFT, "scoreboard_left", 0);
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
